// File: rtl/pq_access_arbiter_pkg.sv
// Shared types for the priority-queue access arbiter: FSM states, queue opcodes
// and response status codes, plus the local admission check.
package pq_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_EMPTY = 2'd1,
        ST_FULL  = 2'd2
    } resp_status_e;

    localparam logic PQ_OP_PUSH = 1'b1;
    localparam logic PQ_OP_POP  = 1'b0;

    // Operations that cannot succeed are answered here and never reach the queue.
    function automatic resp_status_e pq_admit(input logic opcode, input logic [15:0] length,
                                              input int depth);
        if (opcode == PQ_OP_POP && length == 16'd0) return ST_EMPTY;
        if (opcode == PQ_OP_PUSH && int'(length) >= depth) return ST_FULL;
        return ST_OK;
    endfunction

endpackage

// File: rtl/pq_access_arbiter_if.sv
// Requester and queue-side bus of the priority-queue access arbiter.
// slave = arbiter side, master = the environment (requesters plus queue).
interface pq_access_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_opcode;
    logic [NUM_REQ*DATA_W-1:0] req_vertex;
    logic [NUM_REQ*DATA_W-1:0] req_prev_vertex;
    logic [NUM_REQ*DATA_W-1:0] req_dist;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [1:0]                resp_status;
    logic [DATA_W-1:0]         resp_vertex;
    logic [DATA_W-1:0]         resp_prev_vertex;
    logic [DATA_W-1:0]         resp_dist;
    logic                      pq_op_en;
    logic                      pq_opcode;
    logic [DATA_W-1:0]         pq_vertex;
    logic [DATA_W-1:0]         pq_prev_vertex;
    logic [DATA_W-1:0]         pq_dist;
    logic [15:0]               pq_queue_length;
    logic [DATA_W-1:0]         pq_pop_vertex;
    logic [DATA_W-1:0]         pq_pop_prev_vertex;
    logic [DATA_W-1:0]         pq_pop_dist;

    modport slave (
        input  req_valid, req_opcode, req_vertex, req_prev_vertex, req_dist,
        input  pq_queue_length, pq_pop_vertex, pq_pop_prev_vertex, pq_pop_dist,
        output req_ready, resp_valid, resp_status, resp_vertex, resp_prev_vertex, resp_dist,
        output pq_op_en, pq_opcode, pq_vertex, pq_prev_vertex, pq_dist
    );

    modport master (
        output req_valid, req_opcode, req_vertex, req_prev_vertex, req_dist,
        output pq_queue_length, pq_pop_vertex, pq_pop_prev_vertex, pq_pop_dist,
        input  req_ready, resp_valid, resp_status, resp_vertex, resp_prev_vertex, resp_dist,
        input  pq_op_en, pq_opcode, pq_vertex, pq_prev_vertex, pq_dist
    );

endinterface

// File: rtl/pq_access_arbiter_rr_picker.sv
// Masked priority encoder: first asserted request at or after 'start', wrapping
// around, returned both one-hot and as an index.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    always_comb begin
        int j;
        j         = 0;
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(start) + k) % NUM_REQ;
            if (!any && req[j]) begin
                any         = 1'b1;
                grant_oh[j] = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/pq_access_arbiter.sv
// Shares one Dijkstra priority-queue controller among NUM_REQ requesters.
// Round-robin by default; define PQ_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module pq_access_arbiter
    import pq_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 16,
    parameter int PQ_DEPTH      = 64,
    parameter int PQ_OP_LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    pq_access_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = 3;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_oh_q, gnt_oh_d;
    resp_status_e       status_q, status_d;
    logic               pq_op_en_q, pq_op_en_d;
    logic               pq_opcode_q, pq_opcode_d;
    logic [DATA_W-1:0]  pq_vertex_q, pq_vertex_d;
    logic [DATA_W-1:0]  pq_prev_vertex_q, pq_prev_vertex_d;
    logic [DATA_W-1:0]  pq_dist_q, pq_dist_d;
    logic [DATA_W-1:0]  resp_vertex_q, resp_vertex_d;
    logic [DATA_W-1:0]  resp_prev_vertex_q, resp_prev_vertex_d;
    logic [DATA_W-1:0]  resp_dist_q, resp_dist_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   pick_start;
    logic               pick_any;

`ifndef PQ_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    assign pick_start = rr_ptr_q;
`else
    assign pick_start = '0;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req       (bus.req_valid),
        .start     (pick_start),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // The admission check runs at accept time so that pq_op_en can be a flop
    // that is high exactly during the ISSUE cycle.
    always_comb begin
        state_d            = state_q;
        gnt_oh_d           = gnt_oh_q;
        status_d           = status_q;
        pq_op_en_d         = 1'b0;
        pq_opcode_d        = pq_opcode_q;
        pq_vertex_d        = pq_vertex_q;
        pq_prev_vertex_d   = pq_prev_vertex_q;
        pq_dist_d          = pq_dist_q;
        resp_vertex_d      = resp_vertex_q;
        resp_prev_vertex_d = resp_prev_vertex_q;
        resp_dist_d        = resp_dist_q;
        wait_cnt_d         = wait_cnt_q;
`ifndef PQ_ARB_FIXED_PRIO_EN
        rr_ptr_d           = rr_ptr_q;
        gnt_idx_d          = gnt_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_oh_d         = pick_oh;
                    pq_opcode_d      = bus.req_opcode[pick_idx];
                    pq_vertex_d      = bus.req_vertex[int'(pick_idx)*DATA_W +: DATA_W];
                    pq_prev_vertex_d = bus.req_prev_vertex[int'(pick_idx)*DATA_W +: DATA_W];
                    pq_dist_d        = bus.req_dist[int'(pick_idx)*DATA_W +: DATA_W];
                    status_d         = pq_admit(bus.req_opcode[pick_idx], bus.pq_queue_length,
                                                PQ_DEPTH);
                    pq_op_en_d       = (status_d == ST_OK);
`ifndef PQ_ARB_FIXED_PRIO_EN
                    gnt_idx_d        = pick_idx;
`endif
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = '0;
                state_d    = (status_q == ST_OK) ? WAIT : RESP;
            end
            WAIT: begin
                if (wait_cnt_q == CNT_W'(PQ_OP_LATENCY - 1)) begin
                    if (pq_opcode_q == PQ_OP_POP) begin
                        resp_vertex_d      = bus.pq_pop_vertex;
                        resp_prev_vertex_d = bus.pq_pop_prev_vertex;
                        resp_dist_d        = bus.pq_pop_dist;
                    end
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
`ifndef PQ_ARB_FIXED_PRIO_EN
                rr_ptr_d = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= IDLE;
            gnt_oh_q           <= '0;
            status_q           <= ST_OK;
            pq_op_en_q         <= 1'b0;
            pq_opcode_q        <= 1'b0;
            pq_vertex_q        <= '0;
            pq_prev_vertex_q   <= '0;
            pq_dist_q          <= '0;
            resp_vertex_q      <= '0;
            resp_prev_vertex_q <= '0;
            resp_dist_q        <= '0;
            wait_cnt_q         <= '0;
        end else begin
            state_q            <= state_d;
            gnt_oh_q           <= gnt_oh_d;
            status_q           <= status_d;
            pq_op_en_q         <= pq_op_en_d;
            pq_opcode_q        <= pq_opcode_d;
            pq_vertex_q        <= pq_vertex_d;
            pq_prev_vertex_q   <= pq_prev_vertex_d;
            pq_dist_q          <= pq_dist_d;
            resp_vertex_q      <= resp_vertex_d;
            resp_prev_vertex_q <= resp_prev_vertex_d;
            resp_dist_q        <= resp_dist_d;
            wait_cnt_q         <= wait_cnt_d;
        end
    end

`ifndef PQ_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            gnt_idx_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end
`endif

    assign bus.req_ready        = (state_q == IDLE) ? pick_oh : '0;
    assign bus.resp_valid       = (state_q == RESP) ? gnt_oh_q : '0;
    assign bus.resp_status      = status_q;
    assign bus.resp_vertex      = resp_vertex_q;
    assign bus.resp_prev_vertex = resp_prev_vertex_q;
    assign bus.resp_dist        = resp_dist_q;
    assign bus.pq_op_en         = pq_op_en_q;
    assign bus.pq_opcode        = pq_opcode_q;
    assign bus.pq_vertex        = pq_vertex_q;
    assign bus.pq_prev_vertex   = pq_prev_vertex_q;
    assign bus.pq_dist          = pq_dist_q;

endmodule

// File: doc/pq_access_arbiter.md
Name: pq_access_arbiter

Overview:
Shares the single Dijkstra priority-queue controller among NUM_REQ requesters, such as the relaxation engine, the source-seeding unit and the path-readout unit. It accepts one push or pop request at a time using round-robin arbitration. It sequences the queue's op_en/opcode interface, waits the queue's fixed operation latency, and returns a per-requester response. Pop-on-empty and push-on-full are rejected locally and never reach the queue.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 16, width of vertex / prev-vertex / distance fields
PQ_DEPTH, 64, queue capacity; push rejected when pq_queue_length == PQ_DEPTH
PQ_OP_LATENCY, 2, cycles from the pq_op_en cycle until pop data is valid (1..4)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
req_valid  in  NUM_REQ  per-requester request valid
req_opcode  in  NUM_REQ  1 = push, 0 = pop
req_vertex  in  NUM_REQ*DATA_W  push vertex, requester i at slice i
req_prev_vertex  in  NUM_REQ*DATA_W  push predecessor vertex
req_dist  in  NUM_REQ*DATA_W  push distance
req_ready  out  NUM_REQ  one-hot accept strobe
resp_valid  out  NUM_REQ  one-hot response strobe
resp_status  out  2  0 = OK, 1 = EMPTY, 2 = FULL
resp_vertex / resp_prev_vertex / resp_dist  out  DATA_W each  popped entry (broadcast)
pq_op_en  out  1  queue operation strobe
pq_opcode  out  1  to queue
pq_vertex / pq_prev_vertex / pq_dist  out  DATA_W each  push data to queue
pq_queue_length  in  16  current queue occupancy
pq_pop_vertex / pq_pop_prev_vertex / pq_pop_dist  in  DATA_W each  queue pop outputs

Behaviour:
- Reset values: state IDLE, rr_ptr = 0, all strobes 0, resp_status = 0, all data outputs 0, wait counter 0.
- FSM states are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - If any req_valid is high, the winner g is chosen combinationally: the first requester with req_valid high, searching from rr_ptr upward with wrap.
  - req_ready[g] = 1 in the same cycle; the transfer happens at that clock edge.
  - The opcode and data of g are latched. Next state is ISSUE.
- ISSUE:
  - pop with pq_queue_length == 0 → status EMPTY, go to RESP, pq_op_en stays 0.
  - push with pq_queue_length >= PQ_DEPTH → status FULL, go to RESP.
  - Otherwise pq_op_en = 1 for exactly this cycle with latched opcode and data, status OK, go to WAIT.
- WAIT:
  - Counts PQ_OP_LATENCY cycles.
  - On the final WAIT cycle, pq_pop_* are captured into resp_* registers when the latched opcode is pop.
  - Then go to RESP.
- RESP:
  - resp_valid[g] = 1 for one cycle with resp_status.
  - resp_* hold the popped data for a pop; for push or rejection they hold the last values (don't care).
  - rr_ptr <= (g+1) mod NUM_REQ. Next state is IDLE.
- Latency: accept at cycle T, pq_op_en at T+1, resp_valid at T+2+PQ_OP_LATENCY. Rejections respond at T+2.
- Throughput: one operation per (3+PQ_OP_LATENCY) cycles. req_ready is 0 in every state except IDLE.
- Requests that are not granted are held by the requester; no request is dropped.
- rr_ptr advances only on completion of a grant.
- Registered outputs: pq_op_en and pq_* data. Combinational outputs: req_ready and resp_valid, decoded from state.
- Reset mid-operation: immediate return to IDLE with all strobes low. The in-flight requester gets no response and must reissue. The queue may already have executed the operation.

Optional Feature:
PQ_ARB_FIXED_PRIO_EN:
- When defined: fixed priority, lowest index wins; rr_ptr logic is removed.
- When undefined: round-robin as above.

Decomposition:
- Package pq_arb_pkg contains:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - PQ_OP_PUSH = 1'b1 and PQ_OP_POP = 1'b0
  - resp status enum (ST_OK = 0, ST_EMPTY = 1, ST_FULL = 2)
- Sub-module rr_picker: combinational masked priority encoder taking NUM_REQ requests and a start pointer, returning a one-hot grant and an index. With PQ_ARB_FIXED_PRIO_EN it is instantiated with start fixed at 0.

Test Plan:
- Reset, then req0 pushes (vertex 5, prev 2, dist 9) with length 3 → req_ready[0] at T, pq_op_en = 1 with those values at T+1, resp_valid[0] with status OK at T+4.
- req2 pops with length 1 and queue outputs (7, 4, 12) → resp_valid[2] at T+4 with resp_vertex = 7, resp_prev_vertex = 4, resp_dist = 12.
- req1 pops with length 0 → pq_op_en never asserted, resp_valid[1] at T+2 with status EMPTY. A push with length 64 gives status FULL.
- All four requesters held valid → grant order 0, 1, 2, 3, 0 across five operations. With PQ_ARB_FIXED_PRIO_EN defined, requester 0 wins every time.
- Reset asserted during WAIT → next cycle all strobes are 0, state is IDLE and rr_ptr = 0. A re-request is served normally.
- A requester's req_valid drops while another is being served → it is not granted and no spurious resp_valid appears.
